osd_spi_master: RTL

On-chip SPI master that drives the OSD's serial command port (`SPI_SCK`/`SPI_SS3`/`SPI_DI`) from inside the FPGA, so the OSD can be driven by local logic instead of the external controller. It accepts one command at a time: either an OSD enable/disable or a line write. A line write streams bytes from a local byte RAM into the OSD buffer. The serial framing matches what the OSD receiver samples: mode 0, MSB first, one command byte followed by contiguous data bytes, frame delimited by `SPI_SS3`.

---
 rtl/osd_spi_master.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/osd_spi_master.sv
// SPI master for the OSD serial command port: mode 0, MSB first, one command byte
// plus optional line data streamed from a local byte RAM with one-byte prefetch.
module osd_spi_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned SS_GAP  = 4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_enable,
  input  logic [2:0]  cmd_line,
  input  logic [7:0]  cmd_len,
  output logic        rd_en,
  output logic [10:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        SPI_SCK,
  output logic        SPI_SS3,
  output logic        SPI_DO,
  output logic [1:0]  dbg_state
);

  // Command handshake: a command is taken on any clk_sys edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and the command fields are latched on that edge.

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_TAIL  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(SS_GAP - 1);

  logic [1:0]  state_q,   state_d;
  logic [7:0]  div_q,     div_d;
  logic [7:0]  gap_q,     gap_d;
  logic        sck_q,     sck_d;
  logic        ss3_q,     ss3_d;
  logic [7:0]  sh_q,      sh_d;
  logic [2:0]  bit_q,     bit_d;
  logic        wr_q,      wr_d;
  logic [2:0]  line_q,    line_d;
  logic [7:0]  len_q,     len_d;
  logic        is_cmd_q,  is_cmd_d;
  logic [7:0]  idx_q,     idx_d;
  logic [7:0]  pf_q,      pf_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_en_q,   rd_en_d;
  logic [10:0] rd_addr_q, rd_addr_d;

  logic phase_end;
  logic more_bytes;

  assign phase_end  = (div_q == DIV_LAST);
  // Another byte follows the current one: the data bytes after the command byte of a write.
  assign more_bytes = wr_q && (is_cmd_q || (idx_q != len_q));

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    gap_d     = gap_q;
    sck_d     = sck_q;
    ss3_d     = ss3_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    wr_d      = wr_q;
    line_d    = line_q;
    len_d     = len_q;
    is_cmd_d  = is_cmd_q;
    idx_d     = idx_q;
    pf_d      = pf_q;
    rd_en_d   = 1'b0;
    rd_pend_d = rd_en_q;
    rd_addr_d = rd_addr_q;

    // RAM data arrives the cycle after the strobe.
    if (rd_pend_q) begin
      pf_d = rd_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d  = ST_SHIFT;
          ss3_d    = 1'b0;
          sck_d    = 1'b0;
          div_d    = 8'd0;
          bit_d    = 3'd7;
          wr_d     = cmd_write;
          line_d   = cmd_line;
          len_d    = cmd_len;
          is_cmd_d = 1'b1;
          idx_d    = 8'd0;
          sh_d     = cmd_write ? {5'b00100, cmd_line} : {7'b0100000, cmd_enable};
        end
      end

      ST_SHIFT: begin
        if (!phase_end) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = 8'd0;
          if (!sck_q) begin
            sck_d = 1'b1;
            // First rise of a byte: fetch the byte that follows it.
            if ((bit_q == 3'd7) && more_bytes) begin
              rd_en_d   = 1'b1;
              rd_addr_d = {line_q, (is_cmd_q ? 8'd0 : idx_q + 8'd1)};
            end
          end else begin
            sck_d = 1'b0;
            if (bit_q != 3'd0) begin
              bit_d = bit_q - 3'd1;
              sh_d  = {sh_q[6:0], 1'b0};
            end else if (more_bytes) begin
              bit_d = 3'd7;
              sh_d  = pf_q;
              if (is_cmd_q) begin
                is_cmd_d = 1'b0;
                idx_d    = 8'd0;
              end else begin
                idx_d = idx_q + 8'd1;
              end
            end else begin
              state_d = ST_TAIL;
              sh_d    = 8'd0;
            end
          end
        end
      end

      ST_TAIL: begin
        if (!phase_end) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d   = 8'd0;
          state_d = ST_GAP;
          ss3_d   = 1'b1;
          gap_d   = 8'd0;
        end
      end

      default: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = 8'd0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= 8'd0;
      gap_q     <= 8'd0;
      sck_q     <= 1'b0;
      ss3_q     <= 1'b1;
      sh_q      <= 8'd0;
      bit_q     <= 3'd0;
      wr_q      <= 1'b0;
      line_q    <= 3'd0;
      len_q     <= 8'd0;
      is_cmd_q  <= 1'b0;
      idx_q     <= 8'd0;
      pf_q      <= 8'd0;
      rd_pend_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 11'd0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      sck_q     <= sck_d;
      ss3_q     <= ss3_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      wr_q      <= wr_d;
      line_q    <= line_d;
      len_q     <= len_d;
      is_cmd_q  <= is_cmd_d;
      idx_q     <= idx_d;
      pf_q      <= pf_d;
      rd_pend_q <= rd_pend_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign SPI_SCK   = sck_q;
  assign SPI_SS3   = ss3_q;
  assign SPI_DO    = sh_q[7];
  assign dbg_state = state_q;

endmodule
